// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and Gray-code helpers for the async FIFO
//            controllers. The write and read controllers both use these.
// Contents : c_ADDR_W_DEF, c_DATA_W_DEF, bin2gray(), gray2bin()
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_ADDR_W_DEF = 4;
    localparam int c_DATA_W_DEF = 4;

    // The helpers work on 32-bit words so that one function serves every
    // pointer width. Callers zero-extend on the way in and truncate on the
    // way out. Zero upper bits pass through both conversions unchanged.
    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] i_gray);
        logic [31:0] w_bin;
        w_bin[31] = i_gray[31];
        for (int i = 30; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_gray[i];
        end
        return w_bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : STAGES-deep, WIDTH-bit flop synchroniser with a synchronous
//            clear. It is intended for Gray-coded pointers, where only one
//            bit changes at a time. STAGES must be at least 2.
// Ports    : clk  - destination-domain clock
//            rst  - synchronous active-high clear
//            i_d  - asynchronous input bus
//            o_q  - synchronised output (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 captures the raw input. No logic sits in front of it, so the
    // metastability window stays confined to a single flop.
    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_ctrl
// Purpose  : Write-side controller of the async FIFO (clk_a domain). It
//            accepts pushes and drives the memory write port. It also keeps
//            the binary and Gray write pointers, synchronises the read Gray
//            pointer, and derives full, almost-full, level and overflow.
// Ports    : clk_a, rst_i         - write clock, sync active-high reset
//            wr_en_i, wr_data_i   - push request and data
//            rd_ptr_gray_i        - read Gray pointer from clk_b (async)
//            mem_wr_en_o, wr_ptr,
//            mem_wr_data_o        - memory write port
//            wr_ptr_gray_o        - registered write Gray pointer to clk_b
//            full_o, almost_full_o, level_o, overflow_o - status
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEF,
    parameter int DATA_W      = c_DATA_W_DEF,
    parameter int AFULL_TH    = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_a,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W:0]   rd_ptr_gray_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic [ADDR_W:0]   wr_ptr_gray_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
);

    localparam int            c_PW       = ADDR_W + 1;
    localparam logic [ADDR_W:0] c_AFULL_TH = AFULL_TH[ADDR_W:0];

    logic [ADDR_W:0] r_wr_bin;
    logic [ADDR_W:0] w_wr_bin_next;
    logic [ADDR_W:0] w_wr_gray_next;
    logic [ADDR_W:0] w_rq_sync;
    logic [ADDR_W:0] w_rq_bin;
    logic [ADDR_W:0] w_level_next;
    logic            w_full_next;
    logic            w_push;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (c_PW)
    ) u_rq_sync (
        .clk (clk_a),
        .rst (rst_i),
        .i_d (rd_ptr_gray_i),
        .o_q (w_rq_sync)
    );

    // Reset gates the memory strobe. A push that coincides with reset must
    // not land in memory, because the pointer it would have advanced is
    // being discarded.
    assign w_push        = wr_en_i && !full_o && !rst_i;
    assign mem_wr_en_o   = w_push;
    assign mem_wr_data_o = wr_data_i;

    assign w_wr_bin_next  = r_wr_bin + {{ADDR_W{1'b0}}, w_push};
    assign w_wr_gray_next = c_PW'(bin2gray(32'(w_wr_bin_next)));
    assign w_rq_bin       = c_PW'(gray2bin(32'(w_rq_sync)));

    // Full when the write pointer is one lap ahead of the read pointer. In
    // Gray code that means the top two bits are inverted and the rest equal.
    assign w_full_next  = (w_wr_gray_next ==
                           {~w_rq_sync[ADDR_W:ADDR_W-1], w_rq_sync[ADDR_W-2:0]});

    // The read pointer is stale by the synchroniser latency. The level
    // therefore over-counts and never under-counts, which is the safe side.
    assign w_level_next = w_wr_bin_next - w_rq_bin;

    always_ff @(posedge clk_a) begin
        if (rst_i) begin
            r_wr_bin      <= '0;
            wr_ptr        <= '0;
            wr_ptr_gray_o <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            level_o       <= '0;
            overflow_o    <= 1'b0;
        end else begin
            r_wr_bin      <= w_wr_bin_next;
            wr_ptr        <= w_wr_bin_next[ADDR_W-1:0];
            wr_ptr_gray_o <= w_wr_gray_next;
            full_o        <= w_full_next;
            almost_full_o <= (w_level_next >= c_AFULL_TH);
            level_o       <= w_level_next;
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_ctrl
// Purpose  : Directed self-checking bench for fifo_wr_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    logic       clk_a = 1'b0;
    logic       rst_i;
    logic       wr_en_i;
    logic [3:0] wr_data_i;
    logic [4:0] rd_ptr_gray_i;
    logic       mem_wr_en_o;
    logic [3:0] wr_ptr;
    logic [3:0] mem_wr_data_o;
    logic [4:0] wr_ptr_gray_o;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] level_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl #(
        .ADDR_W      (4),
        .DATA_W      (4),
        .AFULL_TH    (14),
        .SYNC_STAGES (2)
    ) dut (
        .clk_a         (clk_a),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .rd_ptr_gray_i (rd_ptr_gray_i),
        .mem_wr_en_o   (mem_wr_en_o),
        .wr_ptr        (wr_ptr),
        .mem_wr_data_o (mem_wr_data_o),
        .wr_ptr_gray_o (wr_ptr_gray_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .level_o       (level_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_a = ~clk_a;

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
        check({tag, "_gray"},   32'(wr_ptr_gray_o), 32'd0);
        check({tag, "_full"},   32'(full_o), 32'd0);
        check({tag, "_afull"},  32'(almost_full_o), 32'd0);
        check({tag, "_level"},  32'(level_o), 32'd0);
        check({tag, "_ovf"},    32'(overflow_o), 32'd0);
    endtask

    initial begin
        logic [4:0] prev_gray;

        rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = 4'd0; rd_ptr_gray_i = 5'd0;
        step(); step();
        rst_i = 1'b0;
        #1;
        check_idle_zero("reset");
        check("reset_memwe", 32'(mem_wr_en_o), 32'd0);

        // Fill all 16 entries with the read pointer parked at 0
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wr_data_i = 4'(i);
            #1;
            check("fill_memwe", 32'(mem_wr_en_o), 32'd1);
            check("fill_addr",  32'(wr_ptr), 32'(i));
            check("fill_data",  32'(mem_wr_data_o), 32'(i));
            step();
            check("fill_level", 32'(level_o), 32'(i + 1));
            check("fill_afull", 32'(almost_full_o), (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_full",  32'(full_o), (i == 15) ? 32'd1 : 32'd0);
        end
        check("fill_gray", 32'(wr_ptr_gray_o), 32'b11000);
        check("fill_ovf",  32'(overflow_o), 32'd0);

        // Push attempts while full
        wr_en_i = 1'b1; wr_data_i = 4'hA;
        #1;
        check("ovf_memwe", 32'(mem_wr_en_o), 32'd0);
        step(); step();
        check("ovf_addr",  32'(wr_ptr), 32'd0);
        check("ovf_flag",  32'(overflow_o), 32'd1);
        check("ovf_level", 32'(level_o), 32'd16);
        check("ovf_gray",  32'(wr_ptr_gray_o), 32'b11000);
        wr_en_i = 1'b0;
        step();
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        check("ovf_full",   32'(full_o), 32'd1);

        // One pop: full drops on the third edge after the change
        rd_ptr_gray_i = 5'b00001;
        step();
        check("pop_full_e1", 32'(full_o), 32'd1);
        step();
        check("pop_full_e2", 32'(full_o), 32'd1);
        step();
        check("pop_full_e3", 32'(full_o), 32'd0);
        check("pop_level",   32'(level_o), 32'd15);
        wr_en_i = 1'b1; wr_data_i = 4'h5;
        #1;
        check("pop_memwe", 32'(mem_wr_en_o), 32'd1);
        check("pop_addr",  32'(wr_ptr), 32'd0);
        step();
        wr_en_i = 1'b0;
        check("pop_addr_after", 32'(wr_ptr), 32'd1);
        check("pop_refull",     32'(full_o), 32'd1);
        check("pop_relevel",    32'(level_o), 32'd16);

        // Fresh fill, then push on the edge the synchronised read pointer moves
        rst_i = 1'b1; rd_ptr_gray_i = 5'd0;
        step();
        rst_i = 1'b0;
        wr_en_i = 1'b1;
        for (int i = 0; i < 16; i++) step();
        wr_en_i = 1'b0;
        check("sim_full0", 32'(full_o), 32'd1);
        check("sim_ovf0",  32'(overflow_o), 32'd0);
        rd_ptr_gray_i = 5'b00001;
        step(); step();
        rd_ptr_gray_i = gray5(2);
        step();
        check("sim_full_drop", 32'(full_o), 32'd0);
        check("sim_level15",   32'(level_o), 32'd15);
        wr_en_i = !full_o;
        #1;
        check("sim_memwe", 32'(mem_wr_en_o), 32'd1);
        step();
        check("sim_full_extra", 32'(full_o), 32'd1);
        check("sim_addr",       32'(wr_ptr), 32'd1);
        check("sim_level16",    32'(level_o), 32'd16);
        check("sim_ovf",        32'(overflow_o), 32'd0);
        wr_en_i = !full_o;
        #1;
        check("sim_memwe_blk", 32'(mem_wr_en_o), 32'd0);
        step();
        check("sim_full_rel", 32'(full_o), 32'd0);
        check("sim_level_rel", 32'(level_o), 32'd15);
        check("sim_addr_hold", 32'(wr_ptr), 32'd1);
        check("sim_ovf_end",  32'(overflow_o), 32'd0);

        // Wrap: 40 pushes with the read pointer following each one
        rst_i = 1'b1; rd_ptr_gray_i = 5'd0;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_gray = wr_ptr_gray_o;
            wr_en_i = 1'b1; wr_data_i = 4'(i);
            step();
            wr_en_i = 1'b0;
            check("wrap_addr",   32'(wr_ptr), 32'((i + 1) % 16));
            check("wrap_gray",   32'(wr_ptr_gray_o), 32'(gray5((i + 1) % 32)));
            check("wrap_onebit", 32'($countones(prev_gray ^ wr_ptr_gray_o)), 32'd1);
            check("wrap_full",   32'(full_o), 32'd0);
            check("wrap_lvl_le2", 32'(level_o <= 5'd2), 32'd1);
            rd_ptr_gray_i = gray5((i + 1) % 32);
            step();
            check("wrap_full_q", 32'(full_o), 32'd0);
            check("wrap_lvl_q",  32'(level_o <= 5'd2), 32'd1);
        end
        step(); step(); step();
        check("wrap_drain", 32'(level_o), 32'd0);

        // Reset at level 9 with a push pending
        wr_en_i = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("l9_level", 32'(level_o), 32'd9);
        check("l9_addr",  32'(wr_ptr), 32'd1);
        rst_i = 1'b1; rd_ptr_gray_i = 5'd0;
        #1;
        check("l9_rst_memwe", 32'(mem_wr_en_o), 32'd0);
        step();
        check_idle_zero("l9_rst");
        rst_i = 1'b0;
        #1;
        check("l9_resume_memwe", 32'(mem_wr_en_o), 32'd1);
        check("l9_resume_addr",  32'(wr_ptr), 32'd0);
        step();
        wr_en_i = 1'b0;
        check("l9_resume_addr1", 32'(wr_ptr), 32'd1);
        check("l9_resume_level", 32'(level_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the async FIFO, clocked entirely in the clk_a (write) domain. It accepts push requests and drives the address, data and write enable of fifo_memory. It keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer into clk_a. From that it produces full, almost-full, fill level and a sticky overflow flag, and exports its own Gray pointer for the read-side controller.

Parameters:
ADDR_W, 4, memory address width; depth = 2**ADDR_W = 16
DATA_W, 4, write data width
AFULL_TH, 14, fill level at or above which almost_full_o asserts
SYNC_STAGES, 2, flop stages on the incoming read Gray pointer (minimum 2)

Ports:
clk_a  in  1  write-domain clock
rst_i  in  1  synchronous, active-high reset
wr_en_i  in  1  push request
wr_data_i  in  DATA_W  push data
rd_ptr_gray_i  in  ADDR_W+1  read Gray pointer, launched from clk_b registers, unsynchronised
mem_wr_en_o  out  1  write enable to memory (wr_en_i && !full_o)
wr_ptr  out  ADDR_W  memory write address (registered)
mem_wr_data_o  out  DATA_W  write data to memory (wr_data_i passthrough)
wr_ptr_gray_o  out  ADDR_W+1  registered write Gray pointer, for the read domain
full_o  out  1  FIFO full
almost_full_o  out  1  level_o >= AFULL_TH
level_o  out  ADDR_W+1  conservative fill count, 0..2**ADDR_W
overflow_o  out  1  sticky: a push was attempted while full

Behaviour:
- Reset: all registers clear on a clk_a edge with rst_i=1. This includes wr_bin, wr_ptr, wr_ptr_gray_o, the sync chain, full_o, almost_full_o, level_o and overflow_o.
- Reset priority: rst_i overrides any simultaneous push. A reset mid-operation discards the pointer state; the read side must be reset in the same window.
- Push accept: push = wr_en_i && !full_o. mem_wr_en_o is combinational from that term, so memory captures at the same clk_a edge, at the current wr_ptr.
- Pointer update:
  - wr_bin is ADDR_W+1 bits and increments by 1 on each push, wrapping from 2**(ADDR_W+1)-1 to 0.
  - wr_ptr = wr_bin[ADDR_W-1:0], wrapping 15 to 0.
  - wr_ptr_gray_o = wr_bin_next ^ (wr_bin_next >> 1), registered, so exactly one bit changes per push.
- Synchroniser: rd_ptr_gray_i passes through SYNC_STAGES flops to give rq_sync. There is no other logic on the first stage.
- Full flag: registered. full_next = (wr_gray_next == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}).
  - full_o rises on the same edge as the push that fills the last entry.
  - Deassertion is pessimistic: it happens SYNC_STAGES+1 clk_a edges after the read pointer change is stable at rd_ptr_gray_i.
- Level: registered. level_o = wr_bin_next - gray2bin(rq_sync), computed modulo 2**(ADDR_W+1). It never exceeds 2**ADDR_W.
- Almost full: almost_full_o = (level_next >= AFULL_TH), registered, so it is aligned with level_o.
- Overflow: overflow_o sets on any edge with wr_en_i && full_o. It holds until rst_i. The attempted push changes neither pointers nor memory.
- Simultaneous push and read-pointer change: evaluate both on the same edge. Full may stay asserted one extra cycle; this is the pessimistic, safe direction and is allowed.
- No state machine beyond the pointer, flag and sync registers; there is no combinational path from rd_ptr_gray_i to any output.

Decomposition:
- Shared package fifo_pkg:
  - ADDR_W and DATA_W defaults
  - bin2gray and gray2bin functions (the read controller reuses both)
- One sub-module: sync_ff, a SYNC_STAGES-deep, N-bit flop synchroniser with synchronous clear on rst_i. The read controller reuses it for the write pointer.

Test Plan:
- Reset, then 16 pushes of data 0..15 with rd_ptr_gray_i=0:
  - mem_wr_en_o high for 16 cycles, wr_ptr 0..15
  - full_o=1 after the 16th edge, level_o=16, almost_full_o=1 from level 14
  - wr_ptr_gray_o=5'b11000
- From full, wr_en_i=1 for 2 cycles: mem_wr_en_o=0, wr_ptr stays 0, overflow_o=1 and stays 1 with wr_en_i low, level_o stays 16.
- From full, step rd_ptr_gray_i from 0 to 5'b00001 (one pop): full_o drops exactly 3 clk_a edges later, level_o=15, and the next push succeeds at wr_ptr=0.
- Wrap: 40 pushes interleaved with matching rd_ptr_gray_i advances:
  - wr_bin wraps 31 to 0
  - every wr_ptr_gray_o step changes exactly one bit
  - full_o never asserts, level_o never exceeds 2
- Reset at level 9 with wr_en_i=1: next edge gives all outputs 0, no mem write that edge, overflow_o cleared; pushing resumes at wr_ptr=0.
- Push on the same edge the read Gray pointer advances at full: no overflow set, full_o holds at most 1 extra cycle, no entry overwritten (wr_ptr unchanged while full).
